// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and constants for the CPU memory responder
package cpu_mem_pkg;

    localparam int DEF_AW = 10;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } memState_t;

    function automatic int memDepth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-write, single-read word array with combinational read and no reset
module mem_array #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          writeEnable,
    input  logic [AW-1:0] writeAddress,
    input  logic [DW-1:0] writeData,
    input  logic [AW-1:0] readAddress,
    output logic [DW-1:0] readData
);

    logic [DW-1:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (writeEnable) begin
            mem[writeAddress] <= writeData;
        end
    end

    assign readData = mem[readAddress];

endmodule

// File: rtl/cpu_memory.sv
// rtl/cpu_memory.sv - program/data memory responder with image loader and CPU hold control
module cpu_memory
    import cpu_mem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int CLEAR_DATA = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] programAddress,
    output logic [DW-1:0] programData,
    input  logic [AW-1:0] dataAddress,
    input  logic          WE,
    input  logic [DW-1:0] writeData,
    output logic [DW-1:0] readData,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic          load_start,
    output logic          cpu_hold,
    output logic [AW:0]   load_count
);

    localparam int            DEPTH     = memDepth(AW);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    memState_t     state, nextState;
    logic [AW-1:0] ptr;
    logic [AW-1:0] clrPtr;
    logic [AW:0]   loadCount;
    logic          cpuHold;

    logic          accept;
    logic          endLoad;
    logic          clearDone;
    logic          restart;
    logic          dataWe;
    logic [AW-1:0] dataWAddr;
    logic [DW-1:0] dataWData;
    logic [DW-1:0] progRd;
    logic [DW-1:0] dataRd;

    // The clear engine owns the data write port in CLEAR; the datapath owns it only in RUN.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        endLoad   = 1'b0;
        clearDone = 1'b0;
        restart   = 1'b0;
        dataWe    = 1'b0;
        dataWAddr = dataAddress;
        dataWData = writeData;
        case (state)
            LOAD: begin
                accept  = load_valid && !reset;
                endLoad = accept && (load_last || (ptr == LAST_ADDR));
                if (endLoad) begin
                    nextState = (CLEAR_DATA != 0) ? CLEAR : RUN;
                end
            end
            CLEAR: begin
                dataWe    = 1'b1;
                dataWAddr = clrPtr;
                dataWData = '0;
                clearDone = (clrPtr == LAST_ADDR);
                if (clearDone) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                dataWe  = WE;
                restart = load_start;
                if (load_start) begin
                    nextState = LOAD;
                end
            end
            default: begin
                nextState = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            ptr       <= '0;
            clrPtr    <= '0;
            loadCount <= '0;
            cpuHold   <= 1'b1;
        end else begin
            state   <= nextState;
            // Registered from the next state so hold drops on the same edge RUN is entered.
            cpuHold <= (nextState != RUN);
            if (restart) begin
                ptr       <= '0;
                loadCount <= '0;
            end else if (accept) begin
                loadCount <= loadCount + (AW+1)'(1);
                if (ptr != LAST_ADDR) begin
                    ptr <= ptr + AW'(1);
                end
            end
            if (state == CLEAR) begin
                clrPtr <= clearDone ? '0 : clrPtr + AW'(1);
            end
        end
    end

    mem_array #(
        .AW(AW),
        .DW(DW)
    ) prog (
        .clk         (clk),
        .writeEnable (accept),
        .writeAddress(ptr),
        .writeData   (load_data),
        .readAddress (programAddress),
        .readData    (progRd)
    );

    mem_array #(
        .AW(AW),
        .DW(DW)
    ) data (
        .clk         (clk),
        .writeEnable (dataWe),
        .writeAddress(dataWAddr),
        .writeData   (dataWData),
        .readAddress (dataAddress),
        .readData    (dataRd)
    );

    assign programData = cpuHold ? '0 : progRd;
    assign readData    = cpuHold ? '0 : dataRd;
    assign load_ready  = (state == LOAD);
    assign cpu_hold    = cpuHold;
    assign load_count  = loadCount;

endmodule

// File: tb/tb_cpu_memory.sv
// tb/tb_cpu_memory.sv - randomized self-checking bench for cpu_memory against a behavioural model
module tb_cpu_memory;

    logic        clk = 1'b0;
    logic        reset;

    logic [9:0]  aProgAddr, aDataAddr;
    logic [15:0] aProgData, aRData, aWData, aLData;
    logic        aWE, aValid, aLast, aReady, aStart, aHold;
    logic [10:0] aCount;

    logic [9:0]  bProgAddr, bDataAddr;
    logic [15:0] bProgData, bRData, bWData, bLData;
    logic        bWE, bValid, bLast, bReady, bStart, bHold;
    logic [10:0] bCount;

    int checks = 0;
    int errors = 0;

    logic [15:0] progA [0:1023];
    logic [15:0] dataA [0:1023];
    bit          mLoading;
    int          mCount;

    cpu_memory #(.AW(10), .DW(16), .CLEAR_DATA(0)) dutA (
        .clk(clk), .reset(reset),
        .programAddress(aProgAddr), .programData(aProgData),
        .dataAddress(aDataAddr), .WE(aWE), .writeData(aWData), .readData(aRData),
        .load_valid(aValid), .load_data(aLData), .load_last(aLast), .load_ready(aReady),
        .load_start(aStart), .cpu_hold(aHold), .load_count(aCount)
    );

    cpu_memory #(.AW(10), .DW(16), .CLEAR_DATA(1)) dutB (
        .clk(clk), .reset(reset),
        .programAddress(bProgAddr), .programData(bProgData),
        .dataAddress(bDataAddr), .WE(bWE), .writeData(bWData), .readData(bRData),
        .load_valid(bValid), .load_data(bLData), .load_last(bLast), .load_ready(bReady),
        .load_start(bStart), .cpu_hold(bHold), .load_count(bCount)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One loader cycle on A; the model decides whether the word is taken.
    task automatic sendA(input logic [15:0] d, input logic last);
        aValid = 1'b1; aLData = d; aLast = last;
        #1;
        checks++;
        if (aReady !== logic'(mLoading)) begin
            errors++;
            $display("FAIL load_ready word %0d: got %b expected %b", mCount, aReady, mLoading);
        end
        step();
        if (mLoading) begin
            progA[mCount] = d;
            mCount++;
            if (last || mCount == 1024) mLoading = 0;
        end
        aValid = 1'b0; aLast = 1'b0;
    endtask

    task automatic checkProgA(input int addr);
        aProgAddr = 10'(addr);
        #1;
        checks++;
        if (aProgData !== progA[addr]) begin
            errors++;
            $display("FAIL programData[%0d]: got %h expected %h", addr, aProgData, progA[addr]);
        end
    endtask

    task automatic checkDataA(input int addr);
        aDataAddr = 10'(addr);
        #1;
        checks++;
        if (aRData !== dataA[addr]) begin
            errors++;
            $display("FAIL readData[%0d]: got %h expected %h", addr, aRData, dataA[addr]);
        end
    endtask

    task automatic checkStatusA(input string tag, input logic expHold);
        checks++;
        if (aHold !== expHold || aReady !== logic'(mLoading) || aCount !== 11'(mCount)) begin
            errors++;
            $display("FAIL %s status: hold=%b ready=%b count=%0d expected hold=%b ready=%b count=%0d",
                     tag, aHold, aReady, aCount, expHold, mLoading, mCount);
        end
    endtask

    task automatic startA();
        aStart = 1'b1;
        step();
        aStart = 1'b0;
        mLoading = 1; mCount = 0;
        checkStatusA("reload", 1'b1);
    endtask

    // Returns the number of cycles after the last word until B releases the CPU.
    task automatic waitClearB(output int fellAt);
        fellAt = -1;
        for (int i = 1; i <= 1100 && fellAt < 0; i++) begin
            step();
            if (i == 1) begin
                checks++;
                if (bReady !== 1'b0) begin
                    errors++;
                    $display("FAIL clear load_ready: got %b expected 0", bReady);
                end
            end
            if (bHold === 1'b0) fellAt = i;
        end
        checks++;
        if (fellAt != 1024) begin
            errors++;
            $display("FAIL clear duration: hold fell after %0d cycles, expected 1024", fellAt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        aProgAddr = 10'h001; aDataAddr = 10'h002; aWE = 0; aWData = 0; aValid = 0; aLData = 0; aLast = 0; aStart = 0;
        bProgAddr = 10'h001; bDataAddr = 10'h002; bWE = 0; bWData = 0; bValid = 0; bLData = 0; bLast = 0; bStart = 0;
        step(); step();
        mLoading = 1; mCount = 0;
        checkStatusA("reset A", 1'b1);
        checks++;
        if (aProgData !== 16'h0 || aRData !== 16'h0) begin
            errors++;
            $display("FAIL reset A outputs: prog=%h read=%h expected 0000 0000", aProgData, aRData);
        end
        checks++;
        if (bHold !== 1'b1 || bReady !== 1'b1 || bCount !== 11'd0 || bProgData !== 16'h0 || bRData !== 16'h0) begin
            errors++;
            $display("FAIL reset B: hold=%b ready=%b count=%0d prog=%h read=%h", bHold, bReady, bCount, bProgData, bRData);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_load_run();
        sendA(16'h1001, 0);
        sendA(16'h2002, 0);
        sendA(16'h3003, 1);
        checkStatusA("load 3", 1'b0);
        checkProgA(1);
        checkProgA(2);
        checkProgA(0);
        checks++;
        if (aProgData !== 16'h1001) begin
            errors++;
            $display("FAIL programData[0] literal: got %h expected 1001", aProgData);
        end
    endtask

    task automatic test_random_load();
        int n;
        startA();
        checks++;
        if (aProgData !== 16'h0) begin
            errors++;
            $display("FAIL hold forcing: got %h expected 0000", aProgData);
        end
        n = $urandom_range(5, 20);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) step();
            sendA(16'($urandom), logic'(i == n - 1));
        end
        checkStatusA("random load", 1'b0);
        for (int i = 0; i < n; i++) checkProgA(i);
    endtask

    task automatic test_data_port();
        int addrs [16];
        int cnt0;
        aDataAddr = 10'h3FE; aWE = 1'b1; aWData = 16'hA5A5;
        step();
        dataA[10'h3FE] = 16'hA5A5;
        aWE = 1'b0; aWData = 16'h1234;
        checkDataA(10'h3FE);
        step();
        checkDataA(10'h3FE);
        for (int i = 0; i < 16; i++) begin
            addrs[i] = $urandom_range(0, 1023);
            aDataAddr = 10'(addrs[i]); aWE = 1'b1; aWData = 16'($urandom);
            step();
            dataA[addrs[i]] = aWData;
        end
        aWE = 1'b0;
        for (int i = 0; i < 16; i++) checkDataA(addrs[i]);
        cnt0 = mCount;
        for (int i = 0; i < 4; i++) sendA(16'($urandom), logic'($urandom_range(0, 1)));
        checks++;
        if (aCount !== 11'(cnt0)) begin
            errors++;
            $display("FAIL run ignores loader: count %0d expected %0d", aCount, cnt0);
        end
        checkStatusA("run idle", 1'b0);
        checkProgA(0);
    endtask

    task automatic test_overflow();
        int a;
        startA();
        for (int i = 0; i < 1025; i++) sendA(16'($urandom), 1'b0);
        checkStatusA("overflow", 1'b0);
        checks++;
        if (aCount !== 11'd1024) begin
            errors++;
            $display("FAIL overflow count: got %0d expected 1024", aCount);
        end
        checkProgA(0);
        checkProgA(1023);
        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(0, 1023);
            checkProgA(a);
        end
    endtask

    task automatic test_clear();
        int fellAt;
        bValid = 1'b1; bLData = 16'($urandom); bLast = 1'b1;
        step();
        bValid = 1'b0; bLast = 1'b0;
        waitClearB(fellAt);
        bDataAddr = 10'h3FE; bWE = 1'b1; bWData = 16'hBEEF;
        step();
        bWE = 1'b0;
        #1;
        checks++;
        if (bRData !== 16'hBEEF) begin
            errors++;
            $display("FAIL pre-clear write: got %h expected beef", bRData);
        end
        bStart = 1'b1;
        step();
        bStart = 1'b0;
        checks++;
        if (bHold !== 1'b1 || bReady !== 1'b1 || bCount !== 11'd0) begin
            errors++;
            $display("FAIL B reload: hold=%b ready=%b count=%0d expected 1 1 0", bHold, bReady, bCount);
        end
        bValid = 1'b1; bLData = 16'hC0DE; bLast = 1'b1;
        step();
        bValid = 1'b0; bLast = 1'b0;
        waitClearB(fellAt);
        bProgAddr = 10'h000;
        #1;
        checks++;
        if (bRData !== 16'h0 || bCount !== 11'd1 || bProgData !== 16'hC0DE) begin
            errors++;
            $display("FAIL after clear: read=%h count=%0d prog=%h expected 0000 1 c0de", bRData, bCount, bProgData);
        end
    endtask

    task automatic test_reload_reset();
        logic [15:0] v;
        v = 16'($urandom);
        aDataAddr = 10'h155; aWE = 1'b1; aWData = v; aStart = 1'b1;
        step();
        dataA[10'h155] = v;
        aWE = 1'b0; aStart = 1'b0;
        mLoading = 1; mCount = 0;
        checkStatusA("reload with WE", 1'b1);
        sendA(16'($urandom), 0);
        sendA(16'($urandom), 0);
        reset = 1'b1;
        #1;
        mCount = 0;
        checkStatusA("async reset", 1'b1);
        step();
        reset = 1'b0;
        step();
        mLoading = 1; mCount = 0;
        sendA(16'($urandom), 1);
        checkStatusA("after reset load", 1'b0);
        checkProgA(0);
        checkProgA(1);
        checkDataA(10'h155);
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_random_load();
        test_data_port();
        test_overflow();
        test_clear();
        test_reload_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
